// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box table, round-constant helpers, key-expansion state and round-key types.
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [127:0] rk_t;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // GF(2^8) multiply by x, reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: combinational byte substitution, no latency, no flow control.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per clock into an 11-entry register file, read back combinationally.
// start -> done 10 edges later; start is ignored while busy (no backpressure beyond that).
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  generate
    if (NR != 10) begin : g_bad_nr
      $error("aes_key_expand supports only NR=10 (AES-128)");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t      r_state;
  logic [3:0]  r_round;
  logic [7:0]  r_rcon;
  logic        r_busy;
  logic        r_done;
  logic        r_valid;
  rk_t         r_rk [0:10];

  logic [3:0]  w_prev_idx;
  rk_t         w_prev;
  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_t;
  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;
  logic [31:0] w_n3;
  rk_t         w_next;

  // r_round is 0 only in IDLE after reset; the guard keeps the index in range.
  assign w_prev_idx = (r_round == 4'd0) ? 4'd0 : r_round - 4'd1;
  assign w_prev     = r_rk[w_prev_idx];
  assign w_rot      = {w_prev[23:0], w_prev[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .i_byte (w_rot[gi*8 +: 8]),
        .o_byte (w_sub[gi*8 +: 8])
      );
    end
  endgenerate

  assign w_t    = w_sub ^ {r_rcon, 24'h0};
  assign w_n0   = w_prev[127:96] ^ w_t;
  assign w_n1   = w_prev[95:64]  ^ w_n0;
  assign w_n2   = w_prev[63:32]  ^ w_n1;
  assign w_n3   = w_prev[31:0]   ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_round <= 4'd0;
      r_rcon  <= RCON_INIT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i <= 10; i++) begin
        r_rk[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rk[0] <= key_in;
            r_round <= 4'd1;
            r_rcon  <= RCON_INIT;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= EXPAND;
          end
        end
        EXPAND: begin
          r_rk[r_round] <= w_next;
          r_round       <= r_round + 4'd1;
          r_rcon        <= xtime(r_rcon);
          if (r_round == LAST_ROUND) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign valid  = r_valid;
  assign rk_out = (rk_idx <= 4'd10) ? r_rk[rk_idx] : '0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: stimulus queues expected round keys, a done-triggered monitor checks them.
module tb_aes_key_expand;

  localparam logic [127:0] K_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] key;
    logic [127:0] r1;
    logic [127:0] r10;
    int           start_edge;
  } exp_t;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  logic [3:0]   stim_idx;
  logic [3:0]   mon_idx;
  logic         mon_active;
  int           mon_cnt;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  exp_t         sb[$];

  assign rk_idx = mon_active ? mon_idx : stim_idx;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  aes_key_expand #(.NR(10)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .key_in  (key_in),
    .busy    (busy),
    .done    (done),
    .valid   (valid),
    .rk_idx  (rk_idx),
    .rk_out  (rk_out)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Drive start for one cycle and queue what the monitor must see at done.
  task automatic do_start(input logic [127:0] key, input logic [127:0] r1, input logic [127:0] r10);
    exp_t e;
    @(posedge sys_clk);
    #1;
    key_in = key;
    start  = 1'b1;
    e.key = key;
    e.r1  = r1;
    e.r10 = r10;
    e.start_edge = cyc + 1;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_mon(input int target);
    for (int k = 0; k < 40 && mon_cnt < target; k++) @(posedge sys_clk);
    if (mon_cnt < target) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: %0d results seen, needed %0d", mon_cnt, target);
    end
    @(negedge sys_clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    mon_active = 1'b0;
    mon_idx    = 4'd0;
    mon_cnt    = 0;
    forever begin
      @(negedge sys_clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = sb.pop_front();
          // Done is visible after the 10th edge following the start edge (the 11th cycle).
          chk("done_latency", 128'(cyc - e.start_edge), 128'd10);
          chk("valid_at_done", {127'd0, valid}, 128'd1);
          chk("busy_at_done", {127'd0, busy}, 128'd0);
          mon_active = 1'b1;
          mon_idx = 4'd0;  #1 chk("rk0", rk_out, e.key);
          mon_idx = 4'd1;  #1 chk("rk1", rk_out, e.r1);
          mon_idx = 4'd10; #1 chk("rk10", rk_out, e.r10);
          mon_active = 1'b0;
          @(negedge sys_clk);
          chk("done_single_pulse", {127'd0, done}, 128'd0);
          mon_cnt++;
        end
      end
    end
  end

  initial begin
    sys_rst  = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    stim_idx = 4'd0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    @(negedge sys_clk);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_valid", {127'd0, valid}, 128'd0);
    for (int i = 0; i < 16; i++) begin
      stim_idx = 4'(i);
      #1 chk($sformatf("rst_rk%0d", i), rk_out, 128'd0);
    end

    do_start(K_A, A_R1, A_R10);
    @(negedge sys_clk);
    chk("busy_after_start", {127'd0, busy}, 128'd1);
    wait_mon(1);

    do_start(K_C, C_R1, C_R10);
    @(negedge sys_clk);
    chk("valid_drop_b2b_1", {127'd0, valid}, 128'd0);
    wait_mon(2);

    // A second start during busy cycle 5 must not disturb the expansion.
    do_start(K_A, A_R1, A_R10);
    repeat (4) @(posedge sys_clk);
    #1;
    key_in = K_C;
    start  = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    wait_mon(3);

    // Reset in the middle of busy cycle 4: outputs clear without waiting for a clock.
    do_start(K_C, C_R1, C_R10);
    repeat (3) @(posedge sys_clk);
    #3 sys_rst = 1'b1;
    #1;
    chk("midrst_busy", {127'd0, busy}, 128'd0);
    chk("midrst_valid", {127'd0, valid}, 128'd0);
    chk("midrst_done", {127'd0, done}, 128'd0);
    stim_idx = 4'd0;
    #1 chk("midrst_rk0", rk_out, 128'd0);
    stim_idx = 4'd10;
    #1 chk("midrst_rk10", rk_out, 128'd0);
    void'(sb.pop_back());
    repeat (2) @(posedge sys_clk);
    #3 sys_rst = 1'b0;

    do_start(K_A, A_R1, A_R10);
    wait_mon(4);

    do_start(K_C, C_R1, C_R10);
    @(negedge sys_clk);
    chk("valid_drop_b2b_2", {127'd0, valid}, 128'd0);
    wait_mon(5);

    repeat (15) @(posedge sys_clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    chk("final_valid", {127'd0, valid}, 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
